// File: rtl/jtag_scan_defines.sv
// rtl/jtag_scan_defines.sv - shared FSM encodings, TMS patterns and dmi op codes for the scan master
// TMS patterns are stored LSB-first: bit i is driven during the i-th TCK cycle of that phase.
package jtag_scan_defines;

   typedef enum logic [2:0] {
      ST_TRST    = 3'd0,
      ST_IDLE    = 3'd1,
      ST_PREFIX  = 3'd2,
      ST_SHIFT   = 3'd3,
      ST_POSTFIX = 3'd4,
      ST_PAD     = 3'd5,
      ST_DONE    = 3'd6
   } scan_state_t;

   localparam int STEP_W = 6;

   localparam int DR_PREFIX_LEN = 3;
   localparam int IR_PREFIX_LEN = 4;
   localparam logic [3:0] DR_PREFIX_TMS = 4'b0001;
   localparam logic [3:0] IR_PREFIX_TMS = 4'b0011;

   localparam int POSTFIX_LEN = 2;
   localparam logic [1:0] POSTFIX_TMS = 2'b01;

   localparam logic [1:0] DMI_OP_NOP   = 2'd0;
   localparam logic [1:0] DMI_OP_READ  = 2'd1;
   localparam logic [1:0] DMI_OP_WRITE = 2'd2;

endpackage

// File: rtl/jtag_tck_div.sv
// rtl/jtag_tck_div.sv - TCK half-period divider with fall/rise strobes and registered TCK level
// Strobes mark the clk edge on which TCK toggles; TCK parks low whenever en is low.
module jtag_tck_div #(
   parameter int TCK_DIV = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tck,
   output logic tck_fall_en,
   output logic tck_rise_en
);

   localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TCK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tck_q, tck_d;
   logic          wrap;

   always_comb begin
      wrap        = en && (cnt_q == LAST);
      tck_rise_en = wrap && !tck_q;
      tck_fall_en = wrap && tck_q;
      cnt_d       = cnt_q;
      tck_d       = tck_q;
      if (!en) begin
         cnt_d = '0;
         tck_d = 1'b0;
      end else if (wrap) begin
         cnt_d = '0;
         tck_d = !tck_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         tck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tck_q <= tck_d;
      end
   end

   assign tck = tck_q;

endmodule

// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - JTAG IR/DR scan sequencer driving TCK/TMS/TDI from a request/response port
// Optional JTAG_IDLE_PAD_EN adds IDLE_CYCLES Run-Test/Idle TCKs after each scan before the response.
module jtag_scan_master
   import jtag_scan_defines::*;
#(
   parameter int DR_MAX_W = 40,
   parameter int TCK_DIV  = 5,
   parameter int RST_TCKS = 8
`ifdef JTAG_IDLE_PAD_EN
   ,
   parameter int IDLE_CYCLES = 4
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_is_ir,
   input  logic [5:0]          req_len,
   input  logic [DR_MAX_W-1:0] req_data,
   output logic                rsp_valid,
   output logic [DR_MAX_W-1:0] rsp_data,
   output logic                busy,
   input  logic                tap_reset_req,
   output logic                jtag_TCK,
   output logic                jtag_TMS,
   output logic                jtag_TDI,
   input  logic                jtag_TDO
);

   localparam logic [STEP_W-1:0] MAX_LEN = STEP_W'(DR_MAX_W);

   scan_state_t         state_q, state_d;
   logic [STEP_W-1:0]   cnt_q, cnt_d;
   logic [STEP_W-1:0]   len_q, len_d;
   logic                is_ir_q, is_ir_d;
   logic [DR_MAX_W-1:0] data_q, data_d;
   logic [DR_MAX_W-1:0] rsp_data_q, rsp_data_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                tms_q, tms_d;
   logic                tdi_q, tdi_d;

   logic                tck_run, tck_fall_en, tck_rise_en;
   logic [STEP_W-1:0]   step, last_bit, pfx_last, eff_len;
   logic [3:0]          pfx;

   assign tck_run = (state_q == ST_TRST) || (state_q == ST_PREFIX) || (state_q == ST_SHIFT) ||
                    (state_q == ST_POSTFIX) || (state_q == ST_PAD);

   jtag_tck_div #(.TCK_DIV(TCK_DIV)) u_tck_div (
      .clk         (clk),
      .rst         (rst),
      .en          (tck_run),
      .tck         (jtag_TCK),
      .tck_fall_en (tck_fall_en),
      .tck_rise_en (tck_rise_en)
   );

   // Each phase advances on tck_fall_en, which is also the first clk of the next low phase.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      is_ir_d     = is_ir_q;
      data_d      = data_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = 1'b0;
      ready_d     = ready_q;
      busy_d      = busy_q;
      tms_d       = tms_q;
      tdi_d       = tdi_q;
      step        = cnt_q + 6'd1;
      last_bit    = len_q - 6'd1;
      pfx         = is_ir_q ? IR_PREFIX_TMS : DR_PREFIX_TMS;
      pfx_last    = is_ir_q ? STEP_W'(IR_PREFIX_LEN - 1) : STEP_W'(DR_PREFIX_LEN - 1);
      eff_len     = (req_len > MAX_LEN) ? MAX_LEN : req_len;

      case (state_q)
         ST_TRST: begin
            if (tck_fall_en) begin
               if (cnt_q == STEP_W'(RST_TCKS)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  tms_d   = 1'b0;
                  busy_d  = 1'b0;
                  ready_d = 1'b1;
               end else begin
                  cnt_d = step;
                  tms_d = (step < STEP_W'(RST_TCKS));
               end
            end
         end
         ST_IDLE: begin
            if (tap_reset_req) begin
               state_d = ST_TRST;
               cnt_d   = '0;
               tms_d   = 1'b1;
               busy_d  = 1'b1;
               ready_d = 1'b0;
            end else if (req_valid && ready_q) begin
               data_d     = req_data;
               len_d      = eff_len;
               is_ir_d    = req_is_ir;
               rsp_data_d = '0;
               cnt_d      = '0;
               busy_d     = 1'b1;
               ready_d    = 1'b0;
               if (eff_len == '0) begin
                  state_d     = ST_DONE;
                  rsp_valid_d = 1'b1;
               end else begin
                  state_d = ST_PREFIX;
                  tms_d   = req_is_ir ? IR_PREFIX_TMS[0] : DR_PREFIX_TMS[0];
               end
            end
         end
         ST_PREFIX: begin
            if (tck_fall_en) begin
               if (cnt_q == pfx_last) begin
                  state_d = ST_SHIFT;
                  cnt_d   = '0;
                  tms_d   = (len_q == 6'd1);
                  tdi_d   = data_q[0];
               end else begin
                  cnt_d = step;
                  tms_d = pfx[step[1:0]];
               end
            end
         end
         ST_SHIFT: begin
            if (tck_rise_en)
               rsp_data_d[cnt_q] = jtag_TDO;
            if (tck_fall_en) begin
               if (cnt_q == last_bit) begin
                  state_d = ST_POSTFIX;
                  cnt_d   = '0;
                  tms_d   = POSTFIX_TMS[0];
                  tdi_d   = 1'b1;
               end else begin
                  cnt_d = step;
                  tms_d = (step == last_bit);
                  tdi_d = data_q[step];
               end
            end
         end
         ST_POSTFIX: begin
            if (tck_fall_en) begin
               if (cnt_q == STEP_W'(POSTFIX_LEN - 1)) begin
                  cnt_d = '0;
                  tms_d = 1'b0;
`ifdef JTAG_IDLE_PAD_EN
                  state_d = ST_PAD;
`else
                  state_d     = ST_DONE;
                  rsp_valid_d = 1'b1;
`endif
               end else begin
                  cnt_d = step;
                  tms_d = POSTFIX_TMS[step[0]];
               end
            end
         end
`ifdef JTAG_IDLE_PAD_EN
         ST_PAD: begin
            if (tck_fall_en) begin
               if (cnt_q == STEP_W'(IDLE_CYCLES - 1)) begin
                  state_d     = ST_DONE;
                  cnt_d       = '0;
                  rsp_valid_d = 1'b1;
               end else begin
                  cnt_d = step;
               end
            end
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            tms_d   = 1'b0;
         end
         default: begin
            state_d = ST_TRST;
            cnt_d   = '0;
            tms_d   = 1'b1;
            tdi_d   = 1'b1;
            busy_d  = 1'b1;
            ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_TRST;
         cnt_q       <= '0;
         len_q       <= '0;
         is_ir_q     <= 1'b0;
         data_q      <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b1;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         is_ir_q     <= is_ir_d;
         data_q      <= data_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = busy_q;
   assign jtag_TMS  = tms_q;
   assign jtag_TDI  = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb/tb_jtag_scan_master.sv - table-driven bench with a behavioural TAP (IR 5 bits, dmi 40 bits, IDCODE)
// Build with JTAG_IDLE_PAD_EN defined to exercise the padded variant (IDLE_CYCLES=3).
module tb_jtag_scan_master;
   import jtag_scan_defines::*;

   localparam int TD = 5;
`ifdef JTAG_IDLE_PAD_EN
   localparam int PAD = 3;
`else
   localparam int PAD = 0;
`endif
   localparam logic [39:0] DMI_CAP   = 40'hA5_1234_5678;
   localparam logic [31:0] IDCODE    = 32'h4BA0_0477;
   localparam logic [4:0]  IR_IDCODE = 5'h01;
   localparam logic [4:0]  IR_DMI    = 5'h11;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_is_ir;
   logic [5:0]  req_len;
   logic [39:0] req_data;
   logic        rsp_valid;
   logic [39:0] rsp_data;
   logic        busy, tap_reset_req;
   logic        jtag_TCK, jtag_TMS, jtag_TDI;
   logic        jtag_TDO = 1'b0;

   jtag_scan_master #(
      .DR_MAX_W (40),
      .TCK_DIV  (TD),
      .RST_TCKS (8)
`ifdef JTAG_IDLE_PAD_EN
      ,
      .IDLE_CYCLES (3)
`endif
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_is_ir     (req_is_ir),
      .req_len       (req_len),
      .req_data      (req_data),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .busy          (busy),
      .tap_reset_req (tap_reset_req),
      .jtag_TCK      (jtag_TCK),
      .jtag_TMS      (jtag_TMS),
      .jtag_TDI      (jtag_TDI),
      .jtag_TDO      (jtag_TDO)
   );

   always #5 clk = ~clk;

   typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
                             SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR} tap_t;

   function automatic tap_t tap_next(input tap_t s, input logic tms);
      case (s)
         TLR:     return tms ? TLR   : RTI;
         RTI:     return tms ? SELDR : RTI;
         SELDR:   return tms ? SELIR : CAPDR;
         CAPDR:   return tms ? EX1DR : SHDR;
         SHDR:    return tms ? EX1DR : SHDR;
         EX1DR:   return tms ? UPDR  : PAUDR;
         PAUDR:   return tms ? EX2DR : PAUDR;
         EX2DR:   return tms ? UPDR  : SHDR;
         UPDR:    return tms ? SELDR : RTI;
         SELIR:   return tms ? TLR   : CAPIR;
         CAPIR:   return tms ? EX1IR : SHIR;
         SHIR:    return tms ? EX1IR : SHIR;
         EX1IR:   return tms ? UPIR  : PAUIR;
         PAUIR:   return tms ? EX2IR : PAUIR;
         EX2IR:   return tms ? UPIR  : SHIR;
         default: return tms ? SELDR : RTI;
      endcase
   endfunction

   tap_t        tap_st = TLR;
   logic [4:0]  ir = IR_IDCODE;
   logic [4:0]  ir_sr = '0;
   logic [39:0] dr_sr = '0;
   logic [39:0] dtm_req_data = '0;
   int          dtm_req_cnt = 0;
   int          tck_cnt = 0;
   int          rsp_cnt = 0;
   bit          tms_hist [0:1023];

   always @(posedge jtag_TCK) begin
      tck_cnt <= tck_cnt + 1;
      tms_hist[tck_cnt & 1023] <= jtag_TMS;
      case (tap_st)
         TLR:   ir <= IR_IDCODE;
         CAPIR: ir_sr <= 5'b00001;
         SHIR:  ir_sr <= {jtag_TDI, ir_sr[4:1]};
         UPIR:  ir <= ir_sr;
         CAPDR: dr_sr <= (ir == IR_DMI) ? DMI_CAP : (ir == IR_IDCODE) ? {8'h00, IDCODE} : 40'h0;
         SHDR:  dr_sr <= {jtag_TDI, dr_sr[39:1]};
         UPDR:  if (ir == IR_DMI) begin
                   dtm_req_data <= dr_sr;
                   dtm_req_cnt  <= dtm_req_cnt + 1;
                end
         default: ;
      endcase
      tap_st <= tap_next(tap_st, jtag_TMS);
   end

   always @(negedge jtag_TCK)
      jtag_TDO <= (tap_st == SHDR) ? dr_sr[0] : (tap_st == SHIR) ? ir_sr[0] : 1'b0;

   always @(negedge clk)
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] tms_from(input int base, input int n);
      logic [63:0] r = '0;
      for (int k = 0; k < n; k++) r[k] = tms_hist[(base + k) & 1023];
      return r;
   endfunction

   // Waits for the TAP-reset walk to finish: 8 TMS=1 TCKs plus one TMS=0, busy held until ready.
   task automatic trst_check(input string name);
      int base = tck_cnt;
      bit seen = 1'b0;
      bit busy_ok = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (req_ready) begin
            seen = 1'b1;
            break;
         end
         if (!busy) busy_ok = 1'b0;
      end
      check({name, "_ready"}, 64'(seen), 64'd1);
      check({name, "_busy_held"}, 64'(busy_ok), 64'd1);
      check({name, "_busy_fall"}, 64'(busy), 64'd0);
      check({name, "_tcks"}, 64'(tck_cnt - base), 64'd9);
      check({name, "_tms"}, tms_from(base, 9), 64'h0FF);
      check({name, "_tap_rti"}, 64'(tap_st), 64'(RTI));
   endtask

   typedef struct {
      logic        is_ir;
      logic [5:0]  len;
      logic [39:0] data;
      logic [39:0] exp_rsp;
      int          exp_tcks;
      logic [63:0] exp_tms;
      logic        chk_dmi;
      logic        poke;
      logic [4:0]  exp_ir;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int          base, dmi0, lat, n, rc, exp_lat;
      bit          got;
      logic [39:0] rsp;

      vecs[0] = '{1'b1, 6'd5,  40'h11, 40'h01, 11, 64'h303, 1'b0, 1'b0, IR_DMI};
      vecs[1] = '{1'b0, 6'd40, {6'h10, 32'h0, DMI_OP_WRITE}, DMI_CAP, 45, 64'h0000_0C00_0000_0001, 1'b1, 1'b0, IR_DMI};
      vecs[2] = '{1'b0, 6'd50, 40'h12_3456_789A, DMI_CAP, 45, 64'h0000_0C00_0000_0001, 1'b1, 1'b0, IR_DMI};
      vecs[3] = '{1'b0, 6'd8,  40'hA5, 40'h78, 13, 64'hC01, 1'b0, 1'b1, IR_DMI};
      vecs[4] = '{1'b1, 6'd0,  40'h1F, 40'h00, 0, 64'h0, 1'b0, 1'b0, IR_DMI};
      vecs[5] = '{1'b1, 6'd5,  40'h01, 40'h01, 11, 64'h303, 1'b0, 1'b0, IR_IDCODE};
      vecs[6] = '{1'b0, 6'd32, 40'hFF_FFFF_FFFF, {8'h00, IDCODE}, 37, 64'h0000_000C_0000_0001, 1'b0, 1'b0, IR_IDCODE};
      vecs[7] = '{1'b0, 6'd1,  40'h0, 40'h01, 6, 64'h19, 1'b0, 1'b0, IR_IDCODE};

      rst = 1'b1;
      req_valid = 1'b0;
      req_is_ir = 1'b0;
      req_len = '0;
      req_data = '0;
      tap_reset_req = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tck", 64'(jtag_TCK), 64'd0);
      check("rst_tms", 64'(jtag_TMS), 64'd1);
      check("rst_tdi", 64'(jtag_TDI), 64'd1);
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_data", 64'(rsp_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd1);
      rst = 1'b0;
      trst_check("por");

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("v%0d_ready_idle", i), 64'(req_ready), 64'd1);
         base = tck_cnt;
         dmi0 = dtm_req_cnt;
         req_is_ir = vecs[i].is_ir;
         req_len   = vecs[i].len;
         req_data  = vecs[i].data;
         req_valid = 1'b1;
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         req_data  = '1;
         req_len   = '0;
         lat = 0;
         got = 1'b0;
         for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c == 0) begin
               check($sformatf("v%0d_busy_accept", i), 64'(busy), 64'd1);
               check($sformatf("v%0d_ready_accept", i), 64'(req_ready), 64'd0);
            end
            if (vecs[i].poke) tap_reset_req = (c >= 10 && c < 40);
            if (rsp_valid) begin
               got = 1'b1;
               break;
            end
            lat++;
         end
         tap_reset_req = 1'b0;
         rsp = rsp_data;
         n = (vecs[i].len == 0) ? 0 : vecs[i].exp_tcks + PAD;
         exp_lat = n * 2 * TD;
         check($sformatf("v%0d_rsp_seen", i), 64'(got), 64'd1);
         check($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat));
         check($sformatf("v%0d_rsp_data", i), 64'(rsp), 64'(vecs[i].exp_rsp));
         check($sformatf("v%0d_tcks", i), 64'(tck_cnt - base), 64'(n));
         check($sformatf("v%0d_tms", i), tms_from(base, n), vecs[i].exp_tms);
         check($sformatf("v%0d_tap_ir", i), 64'(ir), 64'(vecs[i].exp_ir));
         if (vecs[i].chk_dmi) begin
            check($sformatf("v%0d_dmi_pulse", i), 64'(dtm_req_cnt - dmi0), 64'd1);
            check($sformatf("v%0d_dmi_data", i), 64'(dtm_req_data), 64'(vecs[i].data));
         end
         @(negedge clk);
         check($sformatf("v%0d_rsp_pulse", i), 64'(rsp_valid), 64'd0);
         check($sformatf("v%0d_rsp_hold", i), 64'(rsp_data), 64'(vecs[i].exp_rsp));
         check($sformatf("v%0d_ready_back", i), 64'(req_ready), 64'd1);
         if (vecs[i].poke) begin
            base = tck_cnt;
            repeat (30) @(negedge clk);
            check($sformatf("v%0d_no_trst", i), 64'(tck_cnt - base), 64'd0);
            check($sformatf("v%0d_still_ready", i), 64'(req_ready), 64'd1);
         end
      end

      // Reset while TCK is high during SHIFT bit 20 of a 40-bit DR scan.
      @(negedge clk);
      base = tck_cnt;
      req_is_ir = 1'b0;
      req_len   = 6'd40;
      req_data  = 40'h55_AAAA_5555;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (tck_cnt - base >= 24) begin
            got = 1'b1;
            break;
         end
      end
      check("mid_reached_bit20", 64'(got), 64'd1);
      check("mid_tck_high", 64'(jtag_TCK), 64'd1);
      rc = rsp_cnt;
      rst = 1'b1;
      #1;
      check("mid_tck", 64'(jtag_TCK), 64'd0);
      check("mid_tms", 64'(jtag_TMS), 64'd1);
      check("mid_tdi", 64'(jtag_TDI), 64'd1);
      check("mid_busy", 64'(busy), 64'd1);
      check("mid_ready", 64'(req_ready), 64'd0);
      check("mid_rsp_data", 64'(rsp_data), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      trst_check("mid_trst");
      check("mid_no_rsp", 64'(rsp_cnt - rc), 64'd0);

      // tap_reset_req wins over a same-cycle request.
      @(negedge clk);
      rc = rsp_cnt;
      req_is_ir = 1'b1;
      req_len   = 6'd5;
      req_data  = 40'h11;
      req_valid = 1'b1;
      tap_reset_req = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      tap_reset_req = 1'b0;
      check("prio_ready", 64'(req_ready), 64'd0);
      check("prio_busy", 64'(busy), 64'd1);
      trst_check("prio_trst");
      check("prio_no_rsp", 64'(rsp_cnt - rc), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
